// File: rtl/pol_mem_sweeper_if.sv
// Bus bundles for the polMEM sweeper: the command/read bus toward polMEM
// and the valid/ready result stream toward the downstream consumer.
`default_nettype none

interface pol_mem_bus_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 9
);
  logic              mode;
  logic [ADDR_W-1:0] mem_addr;
  logic              op;
  logic [1:0]        arg;
  logic [DATA_W-1:0] mem_data;

  modport master (output mode, mem_addr, op, arg, input mem_data);
  modport slave  (input mode, mem_addr, op, arg, output mem_data);
endinterface

interface pol_res_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 9
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_sm;
  logic [DATA_W-1:0] out_tc;

  modport master (output out_valid, out_addr, out_sm, out_tc, input out_ready);
  modport slave  (input out_valid, out_addr, out_sm, out_tc, output out_ready);
endinterface

`default_nettype wire

// File: rtl/pol_mem_sweeper.sv
// pol_mem_sweeper: walks every polMEM address, commands a store, reads the
// sign-magnitude result back and streams it out in SM and two's-complement form.
`default_nettype none

module pol_mem_sweeper #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 9
) (
  input  wire logic       CLK,
  input  wire logic       RST_N,
  input  wire logic       start,
  input  wire logic       op_sel,
  input  wire logic [1:0] arg_sel,
  input  wire logic       rd_only,
  pol_mem_bus_if.master   mem,
  pol_res_if.master       res,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic              rd_only_q;
  logic [DATA_W-1:0] mag_ext;
  logic [DATA_W-1:0] tc_next;

  // Negative zero falls out naturally: -(0) == 0.
  always_comb begin
    mag_ext = {1'b0, mem.mem_data[DATA_W-2:0]};
    tc_next = mem.mem_data[DATA_W-1] ? (-mag_ext) : mag_ext;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= S_IDLE;
      rd_only_q     <= 1'b0;
      mem.mode      <= 1'b0;
      mem.mem_addr  <= '0;
      mem.op        <= 1'b0;
      mem.arg       <= 2'b00;
      res.out_valid <= 1'b0;
      res.out_addr  <= '0;
      res.out_sm    <= '0;
      res.out_tc    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mem.op       <= op_sel;
            mem.arg      <= arg_sel;
            rd_only_q    <= rd_only;
            mem.mem_addr <= '0;
            busy         <= 1'b1;
            if (rd_only) begin
              state <= S_READ;
            end else begin
              mem.mode <= 1'b1;
              state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // polMEM commits on the edge that ends this cycle.
          mem.mode <= 1'b0;
          state    <= S_READ;
        end
        S_READ: begin
          res.out_sm    <= mem.mem_data;
          res.out_tc    <= tc_next;
          res.out_addr  <= mem.mem_addr;
          res.out_valid <= 1'b1;
          state         <= S_EMIT;
        end
        S_EMIT: begin
          if (res.out_valid && res.out_ready) begin
            res.out_valid <= 1'b0;
            if (mem.mem_addr == LAST_ADDR) begin
              mem.mem_addr <= '0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state        <= S_DONE;
            end else begin
              mem.mem_addr <= mem.mem_addr + ADDR_W'(1);
              if (rd_only_q) begin
                state <= S_READ;
              end else begin
                mem.mode <= 1'b1;
                state    <= S_WRITE;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/pol_mem_sweeper.md
Name: pol_mem_sweeper

Overview:
- Initiator/reader for the polMEM interface.
- On start, walks all polMEM addresses. For each address it commands polMEM to evaluate and store a result (write), then reads the stored 9-bit sign-magnitude result back.
- Each result is streamed out over a valid/ready port in both sign-magnitude and two's-complement form.
- Replaces hand-driven stimulus of polMEM; sits between polMEM and the downstream result consumer.

Parameters:
- ADDR_W, 4, polMEM address width; sweep covers 0 .. 2**ADDR_W-1.
- DATA_W, 9, polMEM result width; bit DATA_W-1 is sign, lower bits are magnitude.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- op_sel  in  1  0 = polynomial, 1 = derivative; latched at start.
- arg_sel  in  2  00 = +1, 01 = +2, 10 = -1, 11 = -2; latched at start.
- rd_only  in  1  1 = skip write phase (dump memory contents); latched at start.
- mode  out  1  to polMEM; 1 = write, 0 = read.
- mem_addr  out  ADDR_W  to polMEM address.
- op  out  1  to polMEM op.
- arg  out  2  to polMEM arg.
- mem_data  in  DATA_W  from polMEM output (combinational in read mode).
- out_valid  out  1  result beat available.
- out_ready  in  1  consumer accepts beat.
- out_addr  out  ADDR_W  address of current beat.
- out_sm  out  DATA_W  raw sign-magnitude result.
- out_tc  out  DATA_W  two's-complement equivalent of out_sm.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: async on RST_N low. State = IDLE; mode=0; mem_addr=0; op=0; arg=0; out_valid=0; out_addr=0; out_sm=0; out_tc=0; busy=0; done=0. Release is synchronous to the next CLK edge.
- All outputs are registered.

State machine:
- IDLE: on start=1, latch op_sel/arg_sel/rd_only into op/arg/rd_only_q, set mem_addr=0, busy=1. Go to WRITE, or to READ if rd_only=1. Otherwise stay in IDLE.
- WRITE: mode=1 for exactly one cycle, so polMEM stores at the next CLK edge. Then go to READ.
- READ: mode=0 for one settle cycle. At the end of the cycle, capture mem_data into out_sm, compute out_tc, set out_addr=mem_addr and out_valid=1. Go to EMIT.
- EMIT: hold mode=0 and all out_* stable while out_valid=1 and out_ready=0. On out_valid & out_ready:
  - clear out_valid;
  - if mem_addr is the last address, go to DONE;
  - else increment mem_addr and go to WRITE (or READ if rd_only_q).
- DONE: done=1 for one cycle, busy=0, mem_addr returns to 0. Go to IDLE.
- Per-address latency: 2 cycles without backpressure (1 with rd_only), plus one cycle per beat in EMIT with out_ready held high. 16-address sweep = 48 cycles start-to-done (32 with rd_only).

Conversion and data rules:
- Sign-magnitude to two's complement: if the sign bit is 0, out_tc = out_sm. Otherwise out_tc = -(magnitude), in DATA_W bits.
- Negative zero (1_00000000) converts to 0.
- Range ±255 fits the 9-bit signed range without overflow.
- mode is 0 in every state except WRITE, so polMEM is never written outside WRITE.
- op and arg stay constant for the whole sweep even if op_sel/arg_sel change.

Boundary conditions:
- start while busy: ignored.
- start in the same cycle as the done pulse: ignored; it is accepted from IDLE on the next cycle.
- Address counter: no wrap within a sweep. Each address is emitted exactly once, in order 0..15.
- out_ready high before out_valid: no effect.
- Reset mid-sweep: immediate return to reset values. No done pulse. Any partial beat is discarded.

Test Plan:
- polMEM memory at power-up, rd_only=1, start, out_ready=1 -> 16 beats, addr 0..15, out_sm=0, out_tc=0, done pulse 32 cycles after start, mode never 1.
- op_sel=0, arg_sel=00, start, out_ready=1:
  - addr0 out_sm=000000101, out_tc=+5;
  - addr3 out_sm=100000001, out_tc=9'h1FF (-1);
  - addr10 out_sm=100000101, out_tc=-5;
  - done after 48 cycles.
- op_sel=1, arg_sel=01 -> addr0 out_sm=000110001 (+49); addr8 out_sm=100101111, out_tc=-47.
- op_sel=1, arg_sel=00 with out_ready toggling 1 cycle in 3:
  - out_sm/out_addr hold stable while stalled;
  - no beat lost or duplicated;
  - addr5 out_sm=000000000, out_tc=0.
- start pulsed again mid-sweep and op_sel flipped mid-sweep -> ignored; op/arg unchanged; exactly 16 beats.
- RST_N low during EMIT at addr 7 -> outputs at reset values within the same cycle; no done pulse. A new start afterwards sweeps from addr 0.
